// File: rtl/arp_pkg.sv
// Shared ARP definitions for the receive decoder and the reply encoder.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;
  localparam int          ARP_BODY_LEN   = 28;

  typedef enum logic [2:0] {
    IDLE,
    FIELDS,
    WAIT_END,
    CHECK,
    PRESENT,
    DROP
  } arp_rx_state_t;

  // Opcodes we hand to the reply/learn logic.
  function automatic logic arp_oper_ok(input logic [15:0] oper);
    return (oper == ARP_OPER_REQ) || (oper == ARP_OPER_REPLY);
  endfunction

endpackage

// File: rtl/arp_decode.sv
// ARP body parser: collects the 28-byte ARP body behind the MAC decoder,
// validates it once the FCS verdict arrives, and presents {oper, SHA, SPA}
// on a valid/ready port. Define ARP_STATS_EN to build the saturating
// stat_ok / stat_drop counters; otherwise both read as zero.
module arp_decode
  import arp_pkg::*;
#(
  parameter logic [31:0] IP_ADDR = 32'hC0A80164
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        arp_valid_in,
  input  logic        crc_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_oper,
  output logic [47:0] req_sha,
  output logic [31:0] req_spa,
  output logic        busy,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_drop
);

  arp_rx_state_t r_state, w_next;

  logic [4:0]  r_cnt;
  logic [15:0] r_htype, r_ptype, r_oper;
  logic [7:0]  r_hlen, r_plen;
  logic [47:0] r_sha;
  logic [31:0] r_spa, r_tpa;
  logic        r_avi_d;   // arp_valid_in delayed; resets high so a frame in flight at reset is skipped
  logic        r_ign;     // a frame arrived while presenting; drop it when rx_dv falls

  logic        r_req_valid;
  logic [15:0] r_req_oper;
  logic [47:0] r_req_sha;
  logic [31:0] r_req_spa;

  logic w_byte, w_start, w_shift, w_hdr_ok, w_accept, w_hs, w_drop;

  assign w_byte   = rx_dv && arp_valid_in;
  assign w_start  = w_byte && !r_avi_d;
  assign w_shift  = ((r_state == IDLE) && w_start) || ((r_state == FIELDS) && w_byte);
  assign w_hdr_ok = (r_htype == ARP_HTYPE_ETH) && (r_ptype == ARP_PTYPE_IPV4) &&
                    (r_hlen == 8'd6) && (r_plen == 8'd4) && arp_oper_ok(r_oper) &&
                    (r_tpa == IP_ADDR);
  assign w_accept = (r_state == CHECK) && !crc_err && w_hdr_ok;
  assign w_hs     = r_req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and drop-event pulse.
  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    case (r_state)
      IDLE:     if (w_start) w_next = FIELDS;
      FIELDS: begin
        if (!w_byte)                                w_next = DROP;
        else if (r_cnt == 5'(ARP_BODY_LEN - 1))     w_next = WAIT_END;
      end
      WAIT_END: if (!rx_dv) w_next = CHECK;
      CHECK: begin
        if (w_accept) w_next = PRESENT;
        else begin
          w_next = IDLE;
          w_drop = 1'b1;
        end
      end
      PRESENT:  if (w_hs) w_next = IDLE;
      DROP: begin
        if (!rx_dv) begin
          w_next = IDLE;
          w_drop = 1'b1;
        end
      end
      default:  w_next = IDLE;
    endcase
    if (r_ign && !rx_dv) w_drop = 1'b1;
  end

  // Byte counter and network-order field shift registers; THA is not kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_htype <= '0;
      r_ptype <= '0;
      r_hlen  <= '0;
      r_plen  <= '0;
      r_oper  <= '0;
      r_sha   <= '0;
      r_spa   <= '0;
      r_tpa   <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 5'd1;
      if      (r_cnt < 5'd2)  r_htype <= {r_htype[7:0], rxd};
      else if (r_cnt < 5'd4)  r_ptype <= {r_ptype[7:0], rxd};
      else if (r_cnt == 5'd4) r_hlen  <= rxd;
      else if (r_cnt == 5'd5) r_plen  <= rxd;
      else if (r_cnt < 5'd8)  r_oper  <= {r_oper[7:0], rxd};
      else if (r_cnt < 5'd14) r_sha   <= {r_sha[39:0], rxd};
      else if (r_cnt < 5'd18) r_spa   <= {r_spa[23:0], rxd};
      else if (r_cnt >= 5'd24) r_tpa  <= {r_tpa[23:0], rxd};
    end else if (r_state != FIELDS) begin
      r_cnt <= '0;
    end
  end

  // Edge detect on arp_valid_in and tracking of frames ignored during PRESENT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avi_d <= 1'b1;
      r_ign   <= 1'b0;
    end else begin
      r_avi_d <= arp_valid_in;
      if ((r_state == PRESENT) && w_byte) r_ign <= 1'b1;
      else if (!rx_dv)                    r_ign <= 1'b0;
    end
  end

  // Output message register: loaded only on accept, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_req_oper  <= '0;
      r_req_sha   <= '0;
      r_req_spa   <= '0;
    end else if (w_accept) begin
      r_req_valid <= 1'b1;
      r_req_oper  <= r_oper;
      r_req_sha   <= r_sha;
      r_req_spa   <= r_spa;
    end else if (w_hs) begin
      r_req_valid <= 1'b0;
    end
  end

  assign req_valid = r_req_valid;
  assign req_oper  = r_req_oper;
  assign req_sha   = r_req_sha;
  assign req_spa   = r_req_spa;
  assign busy      = (r_state != IDLE);

`ifdef ARP_STATS_EN
  logic [15:0] r_stat_ok, r_stat_drop;

  // Saturating message counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ok   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_hs && (r_stat_ok != 16'hFFFF))     r_stat_ok   <= r_stat_ok + 16'd1;
      if (w_drop && (r_stat_drop != 16'hFFFF)) r_stat_drop <= r_stat_drop + 16'd1;
    end
  end

  assign stat_ok   = r_stat_ok;
  assign stat_drop = r_stat_drop;
`else
  assign stat_ok   = 16'h0;
  assign stat_drop = 16'h0;
`endif

endmodule
